// File: rtl/mips_regfile_param_if.sv
`default_nettype none
// ============================================================================
// mips_regfile_param_if : register-file access bundle (clear, write, reads, imm)
// Revision: 1.0
// ============================================================================
interface mips_regfile_param_if #(
  parameter int W     = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic                clr_req;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [W-1:0]        wdata;
  logic [NREAD*AW-1:0] raddr;
  logic [NREAD*W-1:0]  rdata;
  logic [15:0]         imm_in;
  logic [1:0]          imm_mode;
  logic [W-1:0]        imm_out;
  logic                ready;

  modport master (
    output clr_req, we, waddr, wdata, raddr, imm_in, imm_mode,
    input  rdata, imm_out, ready
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr, imm_in, imm_mode,
    output rdata, imm_out, ready
  );
endinterface
`default_nettype wire

// File: rtl/mips_regfile_param.sv
`default_nettype none
// ============================================================================
// mips_regfile_param : MIPS GPR file with sweep clear, write bypass, imm extender
// Revision: 1.0
// ============================================================================
module mips_regfile_param #(
  parameter int W     = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_regfile_param_if.slave  bus
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic          is_ready;
  logic          write_en;
  logic          fwd_en;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_port [NREAD];
  logic [W-1:0]  imm_sext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= AW'(1);
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The sweep starts at 1 and stops at DEPTH-1 so entry 0 is never touched.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      CLEAR: begin
        ptr_next = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) begin
          state_next = READY;
          ptr_next   = AW'(1);
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_next = CLEAR;
          ptr_next   = AW'(1);
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = AW'(1);
      end
    endcase
  end

  assign is_ready  = (state == READY);
  assign bus.ready = is_ready;
  assign fwd_en    = bus.we && !bus.clr_req;
  assign write_en  = is_ready && fwd_en && (bus.waddr != '0);

  // Storage has no reset so it can map onto RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (write_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.raddr[i*AW +: AW];

    always_comb begin
      rd_port[i] = '0;
      if (!is_ready || ra == '0) begin
        rd_port[i] = '0;
      end else if (fwd_en && bus.waddr == ra) begin
        rd_port[i] = bus.wdata;
      end else begin
        rd_port[i] = mem[ra];
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.rdata[i*W +: W] = rd_port[i];
    end
  end

  assign imm_sext = {{(W-16){bus.imm_in[15]}}, bus.imm_in};

  always_comb begin
    bus.imm_out = imm_sext;
    case (bus.imm_mode)
      2'd0:    bus.imm_out = imm_sext;
      2'd1:    bus.imm_out = {{(W-16){1'b0}}, bus.imm_in};
      2'd2:    bus.imm_out = W'({bus.imm_in, 16'h0000});
      2'd3:    bus.imm_out = imm_sext << 2;
      default: bus.imm_out = imm_sext;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_param.sv
`default_nettype none
// ============================================================================
// tb_mips_regfile_param : scoreboard bench with random stimulus and array model
// Revision: 1.0
// ============================================================================
module tb_mips_regfile_param;
  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;

  logic clk;
  logic reset;

  mips_regfile_param_if #(.W(W), .AW(AW), .NREAD(NREAD)) bus ();

  mips_regfile_param #(.W(W), .DEPTH(DEPTH), .AW(AW), .NREAD(NREAD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 ready, 1 rdata, 2 imm_out
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural model: register contents plus cycles left before the file is usable.
  logic [W-1:0] m_mem [DEPTH];
  int           clear_left;

  function automatic string kname(int k);
    case (k)
      0:       return "ready";
      1:       return "rdata";
      default: return "imm_out";
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbq.pop_front();
      case (e.kind)
        0:       act = {31'b0, bus.ready};
        1:       act = bus.rdata[e.port*W +: W];
        default: act = bus.imm_out;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s port%0d at %0t: got %h expected %h", kname(e.kind), e.port, $time, act, e.val);
      end
    end
  end

  function automatic logic [31:0] imm_ref(logic [15:0] v, logic [1:0] m);
    int s;
    s = v[15] ? int'(v) - 65536 : int'(v);
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(int'(v));
      2'd2:    return 32'(int'(v)) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic push_exp(int k, int p, logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.port = p;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic push_model();
    logic ok;
    ok = reset && (clear_left == 0);
    push_exp(0, 0, {31'b0, ok});
    for (int p = 0; p < NREAD; p++) begin
      logic [AW-1:0] a;
      logic [31:0]   v;
      a = bus.raddr[p*AW +: AW];
      if (!ok || a == 0)                                  v = '0;
      else if (bus.we && !bus.clr_req && bus.waddr == a)  v = bus.wdata;
      else                                                v = m_mem[a];
      push_exp(1, p, v);
    end
    push_exp(2, 0, imm_ref(bus.imm_in, bus.imm_mode));
  endtask

  task automatic model_zero();
    for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
    clear_left = DEPTH - 1;
  endtask

  task automatic model_edge();
    if (!reset) return;
    if (clear_left > 0)                      clear_left--;
    else if (bus.clr_req)                    model_zero();
    else if (bus.we && bus.waddr != 0)       m_mem[bus.waddr] = bus.wdata;
  endtask

  task automatic cycle();
    push_model();
    @(negedge clk);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.clr_req  = 1'b0;
    bus.we       = 1'b0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.raddr    = '0;
  endtask

  task automatic set_raddr(int p, int a);
    bus.raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_zero();
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  logic [15:0] t_imm  [5] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF};
  logic [1:0]  t_mode [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] t_exp  [5] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, 32'h00007FFF};

  initial begin
    reset        = 1'b1;
    bus.imm_in   = '0;
    bus.imm_mode = '0;
    idle();
    model_zero();
    #2;
    do_reset();

    // Sweep after reset, then every register reads zero.
    repeat (DEPTH - 1) cycle();
    push_exp(0, 0, 32'd1);
    for (int r = 1; r < DEPTH; r += 2) begin
      set_raddr(0, r);
      set_raddr(1, (r + 1) % DEPTH);
      cycle();
    end

    // Basic writes and r0 hardwiring.
    idle();
    bus.we = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'h5;          cycle();
    bus.waddr = 5'd2; bus.wdata = 32'hFFFFFFFD;                  cycle();
    bus.waddr = 5'd0; bus.wdata = 32'hDEADBEEF;                  cycle();
    idle();
    set_raddr(0, 1); set_raddr(1, 2);
    push_exp(1, 0, 32'h5); push_exp(1, 1, 32'hFFFFFFFD);         cycle();
    set_raddr(0, 0);
    push_exp(1, 0, 32'h0);                                       cycle();

    // Same-cycle bypass on both ports, then through the array.
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h1234;
    set_raddr(0, 7); set_raddr(1, 7);
    push_exp(1, 0, 32'h1234); push_exp(1, 1, 32'h1234);          cycle();
    bus.we = 1'b0;
    push_exp(1, 0, 32'h1234); push_exp(1, 1, 32'h1234);          cycle();

    // Clear request beats a simultaneous write.
    idle();
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hAA;         cycle();
    bus.clr_req = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h55;    cycle();
    idle();
    repeat (DEPTH - 1) begin
      push_exp(0, 0, 32'd0);
      cycle();
    end
    set_raddr(0, 3); set_raddr(1, 4);
    push_exp(0, 0, 32'd1); push_exp(1, 0, 32'h0); push_exp(1, 1, 32'h0);
    cycle();

    // Reset mid-sweep restarts a full sweep; writes during it are lost.
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h77;         cycle();
    bus.we = 1'b0; bus.clr_req = 1'b1;                           cycle();
    bus.clr_req = 1'b0;
    repeat (10) cycle();
    do_reset();
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h99;
    set_raddr(0, 5);
    repeat (DEPTH - 1) cycle();
    idle();
    set_raddr(0, 5);
    push_exp(0, 0, 32'd1); push_exp(1, 0, 32'h0);                cycle();

    // Immediate extender corner values.
    for (int k = 0; k < 5; k++) begin
      bus.imm_in   = t_imm[k];
      bus.imm_mode = t_mode[k];
      push_exp(2, 0, t_exp[k]);
      cycle();
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bus.we       = ($urandom_range(0, 2) != 0);
      bus.waddr    = AW'($urandom_range(0, DEPTH - 1));
      bus.wdata    = $urandom();
      bus.clr_req  = ($urandom_range(0, 79) == 0);
      bus.imm_in   = 16'($urandom());
      bus.imm_mode = 2'($urandom_range(0, 3));
      for (int p = 0; p < NREAD; p++) begin
        if ($urandom_range(0, 3) == 0) set_raddr(p, int'(bus.waddr));
        else                           set_raddr(p, $urandom_range(0, DEPTH - 1));
      end
      cycle();
    end

    idle();
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mips_regfile_param.md
Name: mips_regfile_param

Overview:
Parametrised MIPS-style general-purpose register file for the datapath decode stage. It provides NREAD combinational read ports and one synchronous write port, with register 0 hardwired to zero and write-to-read bypass. A sequential clear engine zeroes the storage one entry per cycle, so the array maps to RAM without a per-bit reset. A mode-selectable immediate extender is also included.

Parameters:
W, 32, data width in bits; must be >= 32.
DEPTH, 32, number of registers; power of two, >= 4.
AW, 5, address width; must equal log2(DEPTH).
NREAD, 2, number of read ports, 1..4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
clr_req  in  1  one-cycle pulse that requests a full clear sweep; sampled in READY only.
we  in  1  write enable.
waddr  in  AW  write address.
wdata  in  W  write data.
raddr  in  NREAD*AW  read addresses, flattened; port i uses bits [i*AW +: AW].
rdata  out  NREAD*W  read data, flattened; port i uses bits [i*W +: W].
imm_in  in  16  raw instruction immediate, Instr[15:0].
imm_mode  in  2  0=sign-extend, 1=zero-extend, 2=LUI (imm<<16), 3=branch offset (sign-extend then <<2).
imm_out  out  W  extended immediate (combinational).
ready  out  1  high when the file accepts writes and returns valid reads.

Behaviour:
- Storage: DEPTH x W array with no reset on the array itself. Entry 0 is never written and always reads 0.
- FSM states:
  - CLEAR: ptr (AW bits) walks the array and each visited entry is written to 0.
  - READY: normal operation.
- Reset (reset=0, asynchronous): state=CLEAR, ptr=1, ready=0. All rdata outputs read 0 while ready=0.
- CLEAR, per rising edge: mem[ptr]<=0 and ptr<=ptr+1. When ptr==DEPTH-1, the last entry is written and state<=READY on that same edge.
  - With DEPTH=32, ready rises 31 cycles after reset release.
  - ptr must not wrap into entry 0.
- READY + clr_req=1: state<=CLEAR and ptr<=1 on that edge. A write presented in the same cycle is dropped, because clear wins. ready falls on the next cycle.
- clr_req during CLEAR: ignored; the sweep does not restart.
- Reset asserted mid-sweep: restarts from ptr=1 after release.
- Write: in READY, with we=1, clr_req=0 and waddr!=0, mem[waddr]<=wdata on the rising edge.
  - Writes to address 0, or any write while ready=0, are silently discarded.
- Read, port i (combinational), in priority order:
  - ready=0 -> 0.
  - raddr_i==0 -> 0.
  - Bypass: if we=1, clr_req=0 and waddr==raddr_i -> wdata, the same-cycle forward.
  - Otherwise -> mem[raddr_i].
- Multiple read ports may use the same address simultaneously. Each resolves independently with identical results.
- Immediate extender (combinational; valid regardless of ready):
  - mode0: {{(W-16){imm[15]}}, imm}.
  - mode1: {{(W-16){1'b0}}, imm}.
  - mode2: {{(W-32){1'b0}}, imm, 16'h0}.
  - mode3: mode0 result << 2; the top 2 bits are discarded, width stays W.
- Latency: read 0 cycles. Write is visible through the array 1 cycle after the edge, or through the bypass in the same cycle. Clear takes DEPTH-1 cycles.
- ready is driven directly from state (state==READY) and carries no extra register stage.

Test Plan:
1. Reset pulse, then release: ready=0 for exactly 31 cycles, then 1. All rdata read 0 throughout. Reading regs 1..31 afterwards all return 0.
2. Write 0x00000005 to r1 and 0xFFFFFFFD to r2. Set raddr0=1, raddr1=2 -> rdata0=0x5, rdata1=0xFFFFFFFD. Write 0xDEADBEEF to r0 -> r0 still reads 0.
3. Bypass: we=1, waddr=7, wdata=0x1234, with raddr0=7 and raddr1=7 in the same cycle -> both ports return 0x1234 before the edge and continue to after it.
4. Write r3=0xAA, then pulse clr_req together with we=1, waddr=4, wdata=0x55 -> r4 is not written. ready is low for 31 cycles. Afterwards r3=0 and r4=0.
5. Mid-sweep reset: assert reset at clear cycle 10, release -> a full 31-cycle sweep follows. A write attempted during the sweep is discarded.
6. imm_in=0x8004:
   - mode0 -> 0xFFFF8004.
   - mode1 -> 0x00008004.
   - mode2 -> 0x80040000.
   - mode3 -> 0xFFFE0010.
   - imm_in=0x7FFF, mode0 -> 0x00007FFF.
